// File: rtl/example_gate_net.sv
// example_gate_net: fixed four-gate network y = NAND(NAND(a,b), AND(c,~b,d), NOR(e,f))
// with a register chain per gate, so every input-to-y path has a fixed latency.
// Each stage chain resets to the value it would hold with all inputs at 0.
// Latency parameters are legal in the range 1..8.
module example_gate_net #(
  parameter int T1_LAT  = 1,
  parameter int T2_LAT  = 2,
  parameter int T3_LAT  = 1,
  parameter int OUT_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  output logic y,
  output logic y_valid
);

  // Longest gate stage plus the output stage gives the fill time of the network.
  localparam int MAX_T12   = (T1_LAT > T2_LAT) ? T1_LAT : T2_LAT;
  localparam int MAX_T     = (MAX_T12 > T3_LAT) ? MAX_T12 : T3_LAT;
  localparam int VALID_LAT = MAX_T + OUT_LAT;
  localparam int CNT_W     = $clog2(VALID_LAT + 1);
  localparam logic [CNT_W-1:0] VALID_LAST = CNT_W'(VALID_LAT - 1);

  logic                t1_in_s;
  logic                t2_in_s;
  logic                t3_in_s;
  logic                out_in_s;
  logic [T1_LAT-1:0]   t1_r;
  logic [T2_LAT-1:0]   t2_r;
  logic [T3_LAT-1:0]   t3_r;
  logic [OUT_LAT-1:0]  out_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                y_valid_r;

  // Gate functions feeding the head of each register chain.
  always_comb begin
    t1_in_s  = 1'b1;
    t2_in_s  = 1'b0;
    t3_in_s  = 1'b1;
    out_in_s = 1'b1;
    t1_in_s  = ~(a & b);
    t2_in_s  = c & ~b & d;
    t3_in_s  = ~(e | f);
    out_in_s = ~(t1_r[T1_LAT-1] & t2_r[T2_LAT-1] & t3_r[T3_LAT-1]);
  end

  // Stage t1 chain: NAND(a,b), reset value matches all-zero inputs (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_r <= {T1_LAT{1'b1}};
    end else begin
      t1_r[0] <= t1_in_s;
      for (int i = 1; i < T1_LAT; i++) begin
        t1_r[i] <= t1_r[i-1];
      end
    end
  end

  // Stage t2 chain: AND(c,~b,d), reset value matches all-zero inputs (0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t2_r <= {T2_LAT{1'b0}};
    end else begin
      t2_r[0] <= t2_in_s;
      for (int i = 1; i < T2_LAT; i++) begin
        t2_r[i] <= t2_r[i-1];
      end
    end
  end

  // Stage t3 chain: NOR(e,f), reset value matches all-zero inputs (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t3_r <= {T3_LAT{1'b1}};
    end else begin
      t3_r[0] <= t3_in_s;
      for (int i = 1; i < T3_LAT; i++) begin
        t3_r[i] <= t3_r[i-1];
      end
    end
  end

  // Output chain: NAND of the three stage outputs; y is forced high in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= {OUT_LAT{1'b1}};
    end else begin
      out_r[0] <= out_in_s;
      for (int i = 1; i < OUT_LAT; i++) begin
        out_r[i] <= out_r[i-1];
      end
    end
  end

  // Saturating fill counter: y_valid rises on the VALID_LAT-th edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      y_valid_r <= 1'b0;
    end else if (!y_valid_r) begin
      if (cnt_r == VALID_LAST) begin
        y_valid_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign y       = out_r[OUT_LAT-1];
  assign y_valid = y_valid_r;

endmodule

// File: tb/tb_example_gate_net.sv
// Directed bench for example_gate_net: a default-latency instance and a
// T2_LAT=3 instance share the same inputs; outputs are sampled 1 time unit
// after each rising edge.
module tb_example_gate_net;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0;
  logic y, y_valid, y3, y_valid3;

  int checks   = 0;
  int failures = 0;

  // Input history: hist[0] = inputs captured at the most recent edge, packed {a,b,c,d,e,f}.
  logic [5:0] hist [4];

  always #5 clk = ~clk;

  example_gate_net dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .y(y), .y_valid(y_valid)
  );

  example_gate_net #(.T2_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .y(y3), .y_valid(y_valid3)
  );

  // Delay-line reference: t1/t3 see inputs one edge old, t2 sees inputs t2_lag edges old.
  function automatic logic ref_y(input int t2_lag);
    logic [5:0] v1, v2;
    logic t1, t2, t3;
    v1 = hist[1];
    v2 = hist[t2_lag];
    t1 = ~(v1[5] & v1[4]);
    t2 = v2[3] & ~v2[4] & v2[2];
    t3 = ~(v1[1] | v1[0]);
    return ~(t1 & t2 & t3);
  endfunction

  task automatic set_in(input logic [5:0] v);
    {a, b, c, d, e, f} = v;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) hist[i] = 6'd0;
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {a, b, c, d, e, f};
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(6'($urandom_range(0, 63)));
      step();
      checks++;
      if (y !== 1'b1 || y3 !== 1'b1) begin
        failures++;
        $display("FAIL reset_y cycle=%0d got y=%b y3=%b expected 1", k, y, y3);
      end
      checks++;
      if (y_valid !== 1'b0 || y_valid3 !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid cycle=%0d got %b/%b expected 0/0", k, y_valid, y_valid3);
      end
    end
    set_in(6'b000000);
    rst = 1'b0;
    clear_hist();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (y_valid !== (k >= 3) || y_valid3 !== (k >= 4)) begin
        failures++;
        $display("FAIL valid_rise edge=%0d got %b/%b expected %b/%b", k, y_valid, y_valid3,
                 (k >= 3), (k >= 4));
      end
      checks++;
      if (y !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_y edge=%0d got %b expected 1", k, y);
      end
    end
  endtask

  task automatic test_a_path();
    set_in(6'b100100); // a=1 b=0 c=0 d=1 e=0 f=0
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (y !== 1'b1 || y3 !== 1'b1) begin
        failures++;
        $display("FAIL a_path edge=N+%0d got y=%b y3=%b expected 1", k, y, y3);
      end
    end
  endtask

  task automatic test_c_path();
    logic exp_y [1:5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_y3 [1:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    set_in(6'b001100); // a=0 b=0 c=1 d=1 e=0 f=0
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (y !== exp_y[k]) begin
        failures++;
        $display("FAIL c_path edge=M+%0d got %b expected %b", k, y, exp_y[k]);
      end
      checks++;
      if (y3 !== exp_y3[k]) begin
        failures++;
        $display("FAIL c_path_t2lat3 edge=M+%0d got %b expected %b", k, y3, exp_y3[k]);
      end
    end
  endtask

  task automatic test_recover_and_f();
    logic exp_y [1:4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_y3 [1:4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_in(6'b100100); // a=1 c=0
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (y !== exp_y[k] || y3 !== exp_y3[k]) begin
        failures++;
        $display("FAIL recover edge=K+%0d got %b/%b expected %b/%b", k, y, y3, exp_y[k], exp_y3[k]);
      end
    end
    // f=1 forces t3=0, so raising c again must not pull y low.
    set_in(6'b101101); // a=1 b=0 c=1 d=1 e=0 f=1
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (y !== 1'b1 || y3 !== 1'b1) begin
        failures++;
        $display("FAIL f_hold edge=J+%0d got %b/%b expected 1/1", k, y, y3);
      end
    end
  endtask

  task automatic test_b_toggle();
    logic exp_y [1:4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    set_in(6'b101100); // a=1 b=0 c=1 d=1 e=0 f=0 -> y settles to 0
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (y !== 1'b0 || y3 !== 1'b0) begin
      failures++;
      $display("FAIL b_settle got %b/%b expected 0/0", y, y3);
    end
    set_in(6'b111100); // b -> 1
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (y !== exp_y[k]) begin
        failures++;
        $display("FAIL b_toggle edge=P+%0d got %b expected %b", k, y, exp_y[k]);
      end
      checks++;
      if (y !== ref_y(2) || y3 !== ref_y(3)) begin
        failures++;
        $display("FAIL b_toggle_ref edge=P+%0d got %b/%b expected %b/%b", k, y, y3, ref_y(2), ref_y(3));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      set_in(6'($urandom_range(0, 63)));
      step();
      checks++;
      if (y !== ref_y(2) || y3 !== ref_y(3)) begin
        failures++;
        $display("FAIL random_ref cycle=%0d got %b/%b expected %b/%b", k, y, y3, ref_y(2), ref_y(3));
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(6'b101100); // drive y to 0
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (y !== 1'b0 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got y=%b v=%b expected y=0 v=1", y, y_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y !== 1'b1 || y3 !== 1'b1 || y_valid !== 1'b0 || y_valid3 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got y=%b/%b v=%b/%b expected 1/1 0/0", y, y3, y_valid, y_valid3);
    end
    step();
    rst = 1'b0;
    clear_hist();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (y !== ref_y(2) || y_valid !== (k >= 3)) begin
        failures++;
        $display("FAIL async_recover edge=%0d got y=%b v=%b expected y=%b v=%b", k, y, y_valid,
                 ref_y(2), (k >= 3));
      end
    end
  endtask

  initial begin
    clear_hist();
    test_reset();
    test_a_path();
    test_c_path();
    test_recover_and_f();
    test_b_toggle();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
